// File: rtl/cp0_exc_ctrl_if.sv
// Register-access, source and redirection handshake bundle for cp0_exc_ctrl.
interface cp0_exc_ctrl_if #(
    parameter int N_IRQ  = 6,
    parameter int N_TRAP = 2
);
    logic              we;
    logic [4:0]        addr;
    logic [31:0]       wd;
    logic [31:0]       rd;
    logic [N_IRQ-1:0]  irq;
    logic [N_TRAP-1:0] trap;
    logic [31:0]       pcp4;
    logic              exc_req;
    logic              exc_ack;
    logic              eret;
    logic              exl;
    logic [31:0]       vector;

    modport master (
        output we, addr, wd, irq, trap, pcp4, exc_ack, eret,
        input  rd, exc_req, exl, vector
    );

    modport slave (
        input  we, addr, wd, irq, trap, pcp4, exc_ack, eret,
        output rd, exc_req, exl, vector
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, sticky masked pending bits,
// req/ack redirection and ERET. Defining CP0_TIMER_EN adds Count (9) / Compare (11).
module cp0_exc_ctrl #(
    parameter int unsigned N_IRQ  = 6,
    parameter int unsigned N_TRAP = 2,
    parameter logic [31:0] VEC0   = 32'h0000_0180,
    parameter logic [31:0] VEC1   = 32'h0000_0200
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_ctrl_if.slave bus
);
    localparam int unsigned N_SRC = N_TRAP + N_IRQ;
    localparam int unsigned LO    = 8;
    localparam int unsigned HI    = LO + N_SRC - 1;

    typedef enum logic [1:0] { S_IDLE, S_REQ, S_HANDLER } state_e;

    state_e           state_q, state_d;
    logic             ie_q, ie_d;
    logic             exl_q, exl_d;
    logic             iv_q, iv_d;
    logic             exc_req_q, exc_req_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] clr, src;
    logic [31:0]      epc_q, epc_d;
    logic [N_IRQ-1:0] irq_eff;
    logic             wr_status, wr_cause, wr_epc;
    logic [4:0]       exc_code;
    logic [3:0]       src_id;
    logic             found;
    logic [31:0]      status_rd, cause_rd;

    assign wr_status = bus.we && (bus.addr == 5'd12);
    assign wr_cause  = bus.we && (bus.addr == 5'd13);
    assign wr_epc    = bus.we && (bus.addr == 5'd14);

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tflag_q, tflag_d;
    logic        wr_count, wr_compare;

    assign wr_count   = bus.we && (bus.addr == 5'd9);
    assign wr_compare = bus.we && (bus.addr == 5'd11);

    always_comb begin
        count_d          = wr_count ? bus.wd : count_q + 32'd1;
        compare_d        = wr_compare ? bus.wd : compare_q;
        tflag_d          = wr_compare ? 1'b0 : (tflag_q || (count_q == compare_q));
        irq_eff          = bus.irq;
        irq_eff[N_IRQ-1] = bus.irq[N_IRQ-1] | tflag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '1;
            tflag_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tflag_q   <= tflag_d;
        end
    end
`else
    assign irq_eff = bus.irq;
`endif

    assign src = {irq_eff, bus.trap};

    always_comb begin
        mask_d    = mask_q;
        ie_d      = ie_q;
        iv_d      = iv_q;
        epc_d     = epc_q;
        state_d   = state_q;
        exl_d     = exl_q;
        clr       = '0;
        if (wr_status) begin
            mask_d = bus.wd[HI:LO];
            ie_d   = bus.wd[0];
        end
        if (wr_cause) begin
            iv_d = bus.wd[23];
            clr  = bus.wd[HI:LO];
        end
        // New sources win over W1C; the post-write mask zeroes disabled bits at once
        pend_d = ((pend_q & ~clr) | (src & mask_q)) & mask_d;
        if (wr_epc) epc_d = bus.wd;

        case (state_q)
            S_IDLE: begin
                if (ie_q && !exl_q && (pend_q != '0)) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.exc_ack) begin
                    state_d = S_HANDLER;
                    exl_d   = 1'b1;
                    epc_d   = bus.pcp4;
                end else if ((pend_q == '0) || !ie_q) begin
                    state_d = S_IDLE;
                end
            end
            S_HANDLER: begin
                if (bus.eret) begin
                    state_d = S_IDLE;
                    exl_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        exc_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            iv_q      <= 1'b0;
            exc_req_q <= 1'b0;
            mask_q    <= '0;
            pend_q    <= '0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            iv_q      <= iv_d;
            exc_req_q <= exc_req_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            epc_q     <= epc_d;
        end
    end

    // Source index 0 is bit 8; traps occupy the low indices so they win the SrcId scan
    always_comb begin
        if (pend_q[N_SRC-1:N_TRAP] != '0)     exc_code = 5'd0;
        else if (pend_q[N_TRAP-1:0] != '0)    exc_code = 5'd13;
        else                                  exc_code = 5'd10;
        src_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (pend_q[i] && !found) begin
                src_id = 4'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        status_rd         = '0;
        status_rd[HI:LO]  = mask_q;
        status_rd[1]      = exl_q;
        status_rd[0]      = ie_q;
        cause_rd          = '0;
        cause_rd[HI:LO]   = pend_q;
        cause_rd[6:2]     = exc_code;
        cause_rd[23]      = iv_q;
        cause_rd[27:24]   = src_id;
        case (bus.addr)
`ifdef CP0_TIMER_EN
            5'd9:    bus.rd = count_q;
            5'd11:   bus.rd = compare_q;
`endif
            5'd12:   bus.rd = status_rd;
            5'd13:   bus.rd = cause_rd;
            5'd14:   bus.rd = epc_q;
            default: bus.rd = '0;
        endcase
    end

    assign bus.exc_req = exc_req_q;
    assign bus.exl     = exl_q;
    assign bus.vector  = iv_q ? VEC1 : VEC0;
endmodule
